// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: command codes and issue-FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lcd_pkg;

  // Command codes understood by the LCD image controller.
  localparam logic [3:0] CMD_WRITE     = 4'd0;   // write-out; last command of a sequence
  localparam logic [3:0] CMD_BRIGHT_UP = 4'd1;
  localparam logic [3:0] CMD_BRIGHT_DN = 4'd2;
  localparam logic [3:0] CMD_INVERT    = 4'd3;
  localparam logic [3:0] CMD_GRAY      = 4'd4;
  localparam logic [3:0] CMD_ROT_L     = 4'd5;
  localparam logic [3:0] CMD_ROT_R     = 4'd6;
  localparam logic [3:0] CMD_SHIFT_L   = 4'd7;
  localparam logic [3:0] CMD_SHIFT_R   = 4'd8;
  localparam logic [3:0] CMD_SHIFT_U   = 4'd9;
  localparam logic [3:0] CMD_SHIFT_D   = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y  = 4'd11;
  localparam logic [3:0] CMD_RSVD_LO   = 4'd12;  // first code with no controller meaning
  localparam logic [3:0] CMD_NOP       = 4'hF;   // idle value on the cmd bus

  // Issue FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_REL,
    ST_FINAL
  } issue_state_e;

  // True for codes 12..15, which the controller does not define.
  function automatic logic is_reserved(input logic [3:0] code);
    return code >= CMD_RSVD_LO;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO with registered storage; pointers carry one extra wrap bit.
// Latency: a pushed entry is visible at rd_dat the cycle after the push edge.
// Backpressure: pushes are ignored when full, pops ignored when empty; no bypass.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  input  logic          pop_vld,
  output logic [DW-1:0] pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  // Status: equal indices with differing wrap bits means full.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level   = wr_ptr_q - rd_ptr_q;
    pop_dat = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next storage and pointer values; push and pop may coincide.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_vld && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_vld && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Storage and pointer registers; reset empties the FIFO and clears contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Buffers host command codes and issues them one at a time to the LCD controller; seals after code 0.
// Latency: push to cmd_valid is 2 cycles (pop, then strobe) when empty and not busy; strobes >= 3 cycles apart.
// Backpressure: host_ready drops when the FIFO is full or code 0 was accepted; LCD_CMD_SEQ_FILTER_EN drops codes 12-15.
module lcd_cmd_seq #(
  parameter int DEPTH = 8,            // power of two, >= 2
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    host_cmd,
  input  logic          host_valid,
  output logic          host_ready,
  output logic [3:0]    cmd,
  output logic          cmd_valid,
  input  logic          busy,
  input  logic          done,
  output logic          seq_done,
  output logic [AW:0]   level
`ifdef LCD_CMD_SEQ_FILTER_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  import lcd_pkg::*;

  issue_state_e state_q, state_d;
  logic [3:0]   cmd_q, cmd_d;
  logic         cmd_valid_q, cmd_valid_d;
  logic         seq_done_q, seq_done_d;
  logic         closed_q, closed_d;

  logic         full, empty;
  logic [3:0]   head;
  logic         push_acc;
  logic         code_drop;
  logic         fifo_push, fifo_pop;
  logic         can_pop;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (4)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (fifo_push),
    .push_dat (host_cmd),
    .pop_vld  (fifo_pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // Host side: accept, optionally discard reserved codes, and seal on code 0.
  always_comb begin
    host_ready = !full && !closed_q;
    push_acc   = host_valid && host_ready;
`ifdef LCD_CMD_SEQ_FILTER_EN
    code_drop  = is_reserved(host_cmd);
`else
    code_drop  = 1'b0;
`endif
    fifo_push  = push_acc && !code_drop;
    closed_d   = closed_q || (push_acc && (host_cmd == CMD_WRITE));
  end

  // Issue FSM: pop into the cmd register, strobe once, then track the busy pulse.
  always_comb begin
    state_d     = state_q;
    cmd_d       = CMD_NOP;
    cmd_valid_d = 1'b0;
    seq_done_d  = seq_done_q;
    fifo_pop    = 1'b0;
    can_pop     = !empty && !busy;
    case (state_q)
      ST_IDLE: begin
        if (can_pop) begin
          fifo_pop    = 1'b1;
          cmd_d       = head;
          cmd_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // cmd_q still holds the code being strobed this cycle.
        state_d = (cmd_q == CMD_WRITE) ? ST_FINAL : ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Controller raises busy one cycle after it sees the strobe.
        if (busy) begin
          state_d = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        // The release cycle doubles as an IDLE cycle so back-to-back
        // commands go out every 3 cycles instead of 4.
        if (!busy) begin
          if (can_pop) begin
            fifo_pop    = 1'b1;
            cmd_d       = head;
            cmd_valid_d = 1'b1;
            state_d     = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FINAL: begin
        // Sealed: nothing more is issued; only the controller's done matters.
        if (done) begin
          seq_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_NOP;
      cmd_valid_q <= 1'b0;
      seq_done_q  <= 1'b0;
      closed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      seq_done_q  <= seq_done_d;
      closed_q    <= closed_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign seq_done  = seq_done_q;

`ifdef LCD_CMD_SEQ_FILTER_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of reserved codes accepted from the host and discarded.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (push_acc && code_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: table of host codes plus hand sequences for reset, full, spacing and sealing.
// Strobes are scored against a queue of expected codes filled when each push is driven.
// A small controller model raises busy one cycle after each strobe for ctl_hold cycles.
module tb_lcd_cmd_seq;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef LCD_CMD_SEQ_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk, reset;
  logic [3:0]    host_cmd;
  logic          host_valid, host_ready;
  logic [3:0]    cmd;
  logic          cmd_valid, busy, done, seq_done;
  logic [AW:0]   level;
`ifdef LCD_CMD_SEQ_FILTER_EN
  logic [7:0]    drop_cnt;
  int            exp_drops;
`endif

  logic busy_man, busy_ctl, ctl_en;
  int   ctl_hold;
  assign busy = busy_man | busy_ctl;

  int         n_chk, n_pass, cyc, last_push_cyc;
  logic [3:0] exp_q [$];
  int         strobe_cyc [$];
  logic [3:0] mon_exp;

  typedef struct {
    logic [3:0] code;     // host input
    bit         issued;   // expected to appear on cmd
    logic [3:0] exp_cmd;  // expected cmd value when issued
  } vec_t;
  vec_t vecs [15];

  lcd_cmd_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .done       (done),
    .seq_done   (seq_done),
    .level      (level)
`ifdef LCD_CMD_SEQ_FILTER_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: every strobe must match the oldest expected code; idle cmd must be NOP.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (cmd_valid === 1'b1) begin
          strobe_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", {31'd0, cmd_valid}, 32'd0);
          end else begin
            mon_exp = exp_q.pop_front();
            check("strobe_cmd", {28'd0, cmd}, {28'd0, mon_exp});
          end
        end else begin
          check("idle_cmd_nop", {28'd0, cmd}, 32'hF);
        end
      end
    end
  end

  // Controller model: busy one cycle after a strobe, held ctl_hold cycles.
  initial begin
    busy_ctl = 1'b0;
    forever begin
      @(negedge clk);
      if (ctl_en && cmd_valid === 1'b1 && reset === 1'b0) begin
        @(posedge clk);
        #1 busy_ctl = 1'b1;
        repeat (ctl_hold) @(posedge clk);
        #1 busy_ctl = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts and ends 1 time unit after a rising edge; one push attempt per call.
  task automatic push(input logic [3:0] c, input bit acc_exp, input bit sb);
    host_valid = 1'b1;
    host_cmd   = c;
    last_push_cyc = cyc;
    if (acc_exp && sb) exp_q.push_back(c);
    @(negedge clk);
    check("push_host_ready", {31'd0, host_ready}, {31'd0, acc_exp});
    @(posedge clk);
    #1;
    host_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b1; host_valid = 1'b0; host_cmd = 4'd0;
    busy_man = 1'b1; done = 1'b0; ctl_en = 1'b0; ctl_hold = 1;
`ifdef LCD_CMD_SEQ_FILTER_EN
    exp_drops = 0;
`endif
    for (int i = 0; i < 15; i++) begin
      vecs[i].code    = 4'(i + 1);
      vecs[i].issued  = !(FILT && (i + 1) >= 12);
      vecs[i].exp_cmd = 4'(i + 1);
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 0);
    check("rst_cmd", {28'd0, cmd}, 32'hF);
    check("rst_seq_done", {31'd0, seq_done}, 0);
    check("rst_level", {28'd0, level}, 0);
`ifdef LCD_CMD_SEQ_FILTER_EN
    check("rst_drop_cnt", {24'd0, drop_cnt}, 0);
`endif
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_host_ready", {31'd0, host_ready}, 1);
    tick(1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    @(negedge clk);
    check("done_ignored_idle", {31'd0, seq_done}, 0);
    tick(1);

    // Power-up busy: push 1,5,0 then release busy
    push(4'd1, 1, 1); push(4'd5, 1, 1); push(4'd0, 1, 1);
    @(negedge clk);
    check("sealed_host_ready", {31'd0, host_ready}, 0);
    tick(3);
    @(negedge clk);
    check("busy_blocks_issue", {28'd0, level}, 3);
    tick(1);
    strobe_cyc.delete();
    ctl_hold = 1; ctl_en = 1'b1; busy_man = 1'b0;
    wait_drain(40);
    check("seq_strobe_count", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check("seq_spacing_0", strobe_cyc[1] - strobe_cyc[0], 3);
      check("seq_spacing_1", strobe_cyc[2] - strobe_cyc[1], 3);
    end
    tick(4);
    @(negedge clk);
    check("final_waits_done", {31'd0, seq_done}, 0);
    tick(1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    @(negedge clk);
    check("seq_done_set", {31'd0, seq_done}, 1);
    tick(4);
    @(negedge clk);
    check("seq_done_sticky", {31'd0, seq_done}, 1);
    tick(1);
    push(4'd3, 0, 0);
    @(negedge clk);
    check("sealed_level", {28'd0, level}, 0);
    tick(1);
    reset = 1'b1; exp_q.delete(); ctl_en = 1'b0; busy_man = 1'b1;
    @(negedge clk);
    check("rst_clears_seq_done", {31'd0, seq_done}, 0);
    tick(2);
    reset = 1'b0;

    // Full FIFO
    for (int i = 0; i < 8; i++) push(4'd2, 1, 1);
    @(negedge clk);
    check("full_level", {28'd0, level}, 8);
    check("full_host_ready", {31'd0, host_ready}, 0);
    tick(1);
    push(4'd2, 0, 0);
    @(negedge clk);
    check("full_refused_level", {28'd0, level}, 8);
    tick(1);
    strobe_cyc.delete();
    ctl_hold = 1; ctl_en = 1'b1; busy_man = 1'b0;
    @(negedge clk);
    check("full_ready_during_pop", {31'd0, host_ready}, 0);
    tick(1);
    @(negedge clk);
    check("ready_after_pop", {31'd0, host_ready}, 1);
    check("level_after_pop", {28'd0, level}, 7);
    tick(1);
    wait_drain(80);
    check("full_strobe_count", strobe_cyc.size(), 8);
    if (strobe_cyc.size() == 8) begin
      for (int i = 1; i < 8; i++) check("full_spacing", strobe_cyc[i] - strobe_cyc[i-1], 3);
    end
    tick(6);

    // Push-to-strobe latency from empty, not busy
    strobe_cyc.delete();
    push(4'd7, 1, 1);
    wait_drain(20);
    check("latency_strobe_count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() == 1) check("push_to_strobe", strobe_cyc[0] - last_push_cyc, 2);
    tick(6);

    // Code table
    ctl_hold = 2;
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].issued) begin
        exp_q.push_back(vecs[i].exp_cmd);
      end
`ifdef LCD_CMD_SEQ_FILTER_EN
      else exp_drops++;
`endif
      push(vecs[i].code, 1, 0);
      wait_drain(30);
      tick(5);
      @(negedge clk);
      check("vec_level", {28'd0, level}, 0);
`ifdef LCD_CMD_SEQ_FILTER_EN
      check("vec_drop_cnt", {24'd0, drop_cnt}, exp_drops);
`endif
      tick(1);
    end

    // Simultaneous push and pop at level 3
    ctl_en = 1'b0; busy_man = 1'b1;
    push(4'd3, 1, 1); push(4'd4, 1, 1); push(4'd6, 1, 1);
    @(negedge clk);
    check("simul_pre_level", {28'd0, level}, 3);
    tick(1);
    ctl_hold = 1; ctl_en = 1'b1;
    host_valid = 1'b1; host_cmd = 4'd9; exp_q.push_back(4'd9);
    busy_man = 1'b0;
    @(negedge clk);
    check("simul_host_ready", {31'd0, host_ready}, 1);
    tick(1);
    host_valid = 1'b0;
    @(negedge clk);
    check("simul_level", {28'd0, level}, 3);
    tick(1);
    wait_drain(40);
    tick(6);

    // Reset while waiting for busy release with 4 entries queued
    ctl_en = 1'b0; busy_man = 1'b1;
    for (int i = 1; i <= 5; i++) push(4'(i), 1, 1);
    busy_man = 1'b0;
    tick(1);
    busy_man = 1'b1;
    tick(3);
    @(negedge clk);
    check("wrel_level", {28'd0, level}, 4);
    check("wrel_cmd_valid", {31'd0, cmd_valid}, 0);
    tick(1);
    reset = 1'b1; exp_q.delete();
    @(negedge clk);
    check("midrst_level", {28'd0, level}, 0);
    check("midrst_cmd_valid", {31'd0, cmd_valid}, 0);
    check("midrst_cmd", {28'd0, cmd}, 32'hF);
    check("midrst_seq_done", {31'd0, seq_done}, 0);
    tick(1);
    reset = 1'b0; busy_man = 1'b0;
    tick(6);
    @(negedge clk);
    check("after_rst_level", {28'd0, level}, 0);
    check("after_rst_ready", {31'd0, host_ready}, 1);
    tick(1);

`ifdef LCD_CMD_SEQ_FILTER_EN
    // Filter: only the defined code goes out
    busy_man = 1'b1;
    push(4'd12, 1, 0); push(4'd3, 1, 1); push(4'd15, 1, 0);
    @(negedge clk);
    check("filt_level", {28'd0, level}, 1);
    check("filt_drop_cnt", {24'd0, drop_cnt}, 2);
    tick(1);
    ctl_hold = 1; ctl_en = 1'b1; busy_man = 1'b0;
    wait_drain(20);
    tick(6);
    for (int i = 0; i < 260; i++) push(4'd13, 1, 0);
    @(negedge clk);
    check("filt_drop_sat", {24'd0, drop_cnt}, 255);
    check("filt_sat_level", {28'd0, level}, 0);
    tick(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
